// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler sharing one 4x4 int8 tensor core between NUM_REQUESTERS clients.
// Optional performance counters are enabled by defining TENSOR_CORE_SCHEDULER_PERF_EN.
module tensor_core_scheduler #(
   parameter int NUM_REQUESTERS = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                     clock_in,
   input  logic                                     reset_in,
   input  logic [NUM_REQUESTERS-1:0]                req_valid,
   output logic [NUM_REQUESTERS-1:0]                req_ready,
   input  logic [NUM_REQUESTERS-1:0][127:0]         req_matrix_a,
   input  logic [NUM_REQUESTERS-1:0][127:0]         req_matrix_b,
   output logic                                     resp_valid,
   input  logic                                     resp_ready,
   output logic [$clog2(NUM_REQUESTERS)-1:0]        resp_id,
   output logic [127:0]                             resp_matrix,
   output logic                                     resp_error,
   output logic                                     busy,
   output logic [2:0]                               debug_state,
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
   output logic [31:0]                              perf_busy_cycles,
   output logic [15:0]                              perf_jobs_done,
`endif
   output logic                                     tensor_core_register_file_write_enable,
   output logic [3:0][3:0][7:0]                     tensor_core_input1,
   output logic [3:0][3:0][7:0]                     tensor_core_input2,
   input  logic [3:0][3:0][7:0]                     tensor_core_output,
   input  logic                                     is_done_with_calculation
);

   // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high.
   localparam int ID_W  = $clog2(NUM_REQUESTERS);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_CAPTURE = 3'd3,
      S_RESPOND = 3'd4
   } state_t;

   state_t            state, state_next;
   logic [127:0]      op_a, op_b, result;
   logic [ID_W-1:0]   owner, last_grant, grant;
   logic              grant_found;
   logic [CNT_W-1:0]  timeout_cnt;
   logic              resp_error_q;
   logic              done_seen, timeout_hit;

   // First COMPUTE cycle may still see the previous job's done level.
   assign done_seen   = is_done_with_calculation && (timeout_cnt != '0);
   assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant       = '0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQUESTERS;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (grant_found) state_next = S_LOAD;
         S_LOAD:    state_next = S_COMPUTE;
         S_COMPUTE: begin
            if (done_seen)        state_next = S_CAPTURE;
            else if (timeout_hit) state_next = S_RESPOND;
         end
         S_CAPTURE: state_next = S_RESPOND;
         S_RESPOND: if (resp_ready) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && grant_found && !reset_in) req_ready[grant] = 1'b1;
      tensor_core_register_file_write_enable = (state == S_LOAD);
      resp_valid  = (state == S_RESPOND);
      busy        = (state != S_IDLE);
      debug_state = state;
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         op_a         <= '0;
         op_b         <= '0;
         result       <= '0;
         owner        <= '0;
         last_grant   <= ID_W'(NUM_REQUESTERS - 1);
         timeout_cnt  <= '0;
         resp_error_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (grant_found) begin
               op_a       <= req_matrix_a[grant];
               op_b       <= req_matrix_b[grant];
               owner      <= grant;
               last_grant <= grant;
            end
            S_LOAD:    timeout_cnt <= '0;
            S_COMPUTE: begin
               timeout_cnt <= timeout_cnt + 1'b1;
               if (!done_seen && timeout_hit) begin
                  result       <= '0;
                  resp_error_q <= 1'b1;
               end
            end
            S_CAPTURE: result <= tensor_core_output;
            S_RESPOND: if (resp_ready) resp_error_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign resp_id            = owner;
   assign resp_matrix        = result;
   assign resp_error         = resp_error_q;
   assign tensor_core_input1 = op_a;
   assign tensor_core_input2 = op_b;

`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         perf_busy_cycles <= '0;
         perf_jobs_done   <= '0;
      end else begin
         if (busy && perf_busy_cycles != 32'hFFFF_FFFF) perf_busy_cycles <= perf_busy_cycles + 1'b1;
         if (state == S_RESPOND && resp_ready && !resp_error_q) perf_jobs_done <= perf_jobs_done + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Scoreboard bench for tensor_core_scheduler with a multi-cycle behavioural core stub.
module tb_tensor_core_scheduler;
   localparam int N        = 2;
   localparam int W        = 130;
   localparam int STUB_LAT = 2;

   logic                 clock_in = 1'b0;
   logic                 reset_in = 1'b1;
   logic [N-1:0]         req_valid = '0;
   logic [N-1:0]         req_ready;
   logic [N-1:0][127:0]  req_a = '0;
   logic [N-1:0][127:0]  req_b = '0;
   logic                 resp_valid;
   logic                 resp_ready = 1'b1;
   logic [0:0]           resp_id;
   logic [127:0]         resp_matrix;
   logic                 resp_error;
   logic                 busy;
   logic [2:0]           debug_state;
   logic                 we;
   logic [3:0][3:0][7:0] tci1, tci2, tco;
   logic                 is_done;
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
   logic [31:0]          perf_busy_cycles;
   logic [15:0]          perf_jobs_done;
`endif

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clock_in = ~clock_in;

   tensor_core_scheduler #(.NUM_REQUESTERS(N), .TIMEOUT_CYCLES(64)) dut (
      .clock_in(clock_in), .reset_in(reset_in),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_matrix_a(req_a), .req_matrix_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_matrix(resp_matrix), .resp_error(resp_error), .busy(busy),
      .debug_state(debug_state),
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
      .perf_busy_cycles(perf_busy_cycles), .perf_jobs_done(perf_jobs_done),
`endif
      .tensor_core_register_file_write_enable(we),
      .tensor_core_input1(tci1), .tensor_core_input2(tci2),
      .tensor_core_output(tco), .is_done_with_calculation(is_done)
   );

   function automatic logic [127:0] mat_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] c;
      logic [7:0]   acc;
      c = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc = acc + a[(i*4+k)*8 +: 8] * b[(k*4+j)*8 +: 8];
            c[(i*4+j)*8 +: 8] = acc;
         end
      return c;
   endfunction

   function automatic logic [127:0] fill(input logic [7:0] v);
      logic [127:0] m;
      for (int e = 0; e < 16; e++) m[e*8 +: 8] = v;
      return m;
   endfunction

   function automatic logic [127:0] ident();
      logic [127:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[(i*4+i)*8 +: 8] = 8'd1;
      return m;
   endfunction

   function automatic logic [127:0] index_pattern();
      logic [127:0] m;
      for (int e = 0; e < 16; e++) m[e*8 +: 8] = 8'(e);
      return m;
   endfunction

   // Core stub: done stays at its old level for one cycle after a write, then drops.
   logic         stub_done = 1'b0;
   logic         stub_pend = 1'b0;
   logic         done_tie0 = 1'b0;
   int           stub_cnt  = 0;
   logic [127:0] stub_out  = '0;
   logic [127:0] cap_a = '0, cap_b = '0;

   always @(posedge clock_in) begin
      if (we) begin
         stub_pend <= 1'b1;
         stub_cnt  <= STUB_LAT;
         cap_a     <= tci1;
         cap_b     <= tci2;
      end else if (stub_pend) begin
         stub_done <= 1'b0;
         if (stub_cnt == 0) begin
            stub_done <= 1'b1;
            stub_out  <= mat_mul(cap_a, cap_b);
            stub_pend <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end
   assign is_done = stub_done & ~done_tie0;
   assign tco     = stub_out;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard pops on every response handshake, plus per-cycle protocol checks.
   int we_run = 0;
   always @(negedge clock_in) begin
      if (!reset_in) begin
         check("req_ready_onehot", W'((req_ready & (req_ready - 1'b1)) != 0), W'(0));
         if (we) we_run++;
         else if (we_run != 0) begin
            check("we_pulse_len", W'(we_run), W'(1));
            we_run = 0;
         end
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", {resp_error, resp_id, resp_matrix}, '1);
            end else begin
               check("resp", {resp_error, resp_id, resp_matrix}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic do_req(input int id, input logic [127:0] a, input logic [127:0] b);
      logic got;
      got = 1'b0;
      @(posedge clock_in); #1;
      req_a[id] = a;
      req_b[id] = b;
      req_valid[id] = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock_in);
         if (req_ready[id]) begin got = 1'b1; break; end
      end
      check("req_accepted", W'(got), W'(1));
      @(posedge clock_in); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_drain();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clock_in);
         if (exp_q.size() == 0 && !busy && !resp_valid) begin ok = 1'b1; break; end
      end
      check("drain", W'(ok), W'(1));
   endtask

   initial begin
      int n;
      int cnt0, cnt1;
      logic [N-1:0] rdy;

      // Reset state, with a request pending during reset.
      req_valid = 2'b01;
      repeat (3) @(negedge clock_in);
      check("rst_busy", W'(busy), W'(0));
      check("rst_resp_valid", W'(resp_valid), W'(0));
      check("rst_req_ready", W'(req_ready), W'(0));
      check("rst_we", W'(we), W'(0));
      check("rst_resp", {resp_error, resp_id, resp_matrix}, W'(0));
      check("rst_in1", W'(tci1), W'(0));
      @(posedge clock_in); #1;
      req_valid = '0;
      reset_in  = 1'b0;

      // Identity times index pattern returns the pattern.
      exp_q.push_back({1'b0, 1'b0, index_pattern()});
      do_req(0, ident(), index_pattern());
      wait_drain();
      check("busy_after_req0", W'(busy), W'(0));

      // All-2 times all-3: 4*6 = 0x18 everywhere; resp_valid two cycles after a fresh done.
      exp_q.push_back({1'b0, 1'b1, fill(8'h18)});
      do_req(1, fill(8'h02), fill(8'h03));
      n = 0;
      while (is_done && n < 20) begin @(negedge clock_in); n++; end
      while (!is_done && n < 40) begin @(negedge clock_in); n++; end
      check("fresh_done_seen", W'(n < 40), W'(1));
      n = 0;
      while (n < 10) begin
         @(negedge clock_in);
         n++;
         if (resp_valid) break;
      end
      check("done_to_resp_cycles", W'(n), W'(2));
      wait_drain();

      // Both requesters continuously valid: grant order 0,1,0,1.
      exp_q.push_back({1'b0, 1'b0, fill(8'h11)});
      exp_q.push_back({1'b0, 1'b1, fill(8'h04)});
      exp_q.push_back({1'b0, 1'b0, fill(8'h22)});
      exp_q.push_back({1'b0, 1'b1, fill(8'h18)});
      @(posedge clock_in); #1;
      req_a[0] = ident();      req_b[0] = fill(8'h11);
      req_a[1] = fill(8'h01);  req_b[1] = fill(8'h01);
      req_valid = 2'b11;
      cnt0 = 0; cnt1 = 0;
      for (int c = 0; c < 2000 && (cnt0 < 2 || cnt1 < 2); c++) begin
         @(negedge clock_in);
         rdy = req_ready & req_valid;
         @(posedge clock_in); #1;
         if (rdy[0]) begin
            cnt0++;
            if (cnt0 == 1) begin req_a[0] = ident(); req_b[0] = fill(8'h22); end
            else req_valid[0] = 1'b0;
         end
         if (rdy[1]) begin
            cnt1++;
            if (cnt1 == 1) begin req_a[1] = fill(8'h02); req_b[1] = fill(8'h03); end
            else req_valid[1] = 1'b0;
         end
      end
      check("alternation_jobs", W'({cnt0[7:0], cnt1[7:0]}), W'(16'h0202));
      req_valid = '0;
      wait_drain();

      // Timeout: done never reaches the scheduler; error after 64 COMPUTE cycles.
      done_tie0 = 1'b1;
      exp_q.push_back({1'b1, 1'b0, 128'h0});
      do_req(0, fill(8'h01), fill(8'h01));
      n = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock_in);
         if (resp_valid) break;
         n++;
      end
      check("timeout_cycles", W'(n), W'(65));
      wait_drain();
      @(posedge clock_in); #1;
      done_tie0 = 1'b0;
      exp_q.push_back({1'b0, 1'b1, fill(8'h55)});
      do_req(1, ident(), fill(8'h55));
      wait_drain();

      // Response stall with another request pending.
      @(posedge clock_in); #1;
      resp_ready = 1'b0;
      exp_q.push_back({1'b0, 1'b0, fill(8'h77)});
      do_req(0, ident(), fill(8'h77));
      n = 0;
      while (!resp_valid && n < 100) begin @(negedge clock_in); n++; end
      check("stall_resp_seen", W'(resp_valid), W'(1));
      @(posedge clock_in); #1;
      req_a[0] = ident(); req_b[0] = fill(8'h33);
      req_valid[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock_in);
         check("stall_req_ready", W'(req_ready), W'(0));
         check("stall_resp", {resp_valid, resp_error, resp_id, resp_matrix}, {1'b1, 1'b0, 1'b0, fill(8'h77)});
      end
      exp_q.push_back({1'b0, 1'b0, fill(8'h33)});
      @(posedge clock_in); #1;
      resp_ready = 1'b1;
      @(negedge clock_in);
      check("accept_cycle_valid", W'(resp_valid), W'(1));
      @(negedge clock_in);
      check("post_accept_valid", W'(resp_valid), W'(0));
      check("post_accept_busy", W'(busy), W'(0));
      check("post_accept_ready", W'(req_ready), W'(2'b01));
      @(posedge clock_in); #1;
      req_valid[0] = 1'b0;
      wait_drain();

      // Async reset mid-COMPUTE abandons the job silently.
      do_req(1, fill(8'h01), fill(8'h02));
      @(negedge clock_in);
      @(negedge clock_in);
      #2 reset_in = 1'b1;
      req_valid = 2'b11;
      #1;
      check("arst_outputs", {busy, resp_valid, we, req_ready, resp_error, resp_id}, W'(0));
      check("arst_in1", W'(tci1), W'(0));
      check("arst_in2", W'(tci2), W'(0));
      check("arst_matrix", W'(resp_matrix), W'(0));
      @(posedge clock_in); #1;
      reset_in = 1'b0;
      #1;
      check("post_rst_grant_both", W'(req_ready), W'(2'b01));
      req_a[1] = fill(8'h01); req_b[1] = fill(8'h03);
      req_valid = 2'b10;
      exp_q.push_back({1'b0, 1'b1, fill(8'h0C)});
      #1;
      check("post_rst_grant_req1", W'(req_ready), W'(2'b10));
      @(posedge clock_in); #1;
      req_valid = '0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
